vx_mem_chan_interleave: RTL

- Splits the single top-level memory request stream from the last cache level across NUM_CHANNELS independent memory channels, using address-interleaved channel selection.
- Merges the channel responses back into one response stream with a round-robin arbiter.
- Tracks outstanding reads per channel and derives busy and memory perf counters (reads, writes, latency).
- Sits between the L3/passthru memory bus and the platform memory controllers; generalises the single-port memory interface to N channels.

---
 rtl/vx_mem_chan_interleave_if.sv | 65 ++++++
 rtl/vx_mem_chan_interleave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_chan_interleave_if.sv
// vx_mem_chan_interleave_if: single-stream memory side plus
// N-channel memory side of the channel interleaver.
interface vx_mem_chan_interleave_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_WIDTH    = 8
);
  localparam int CH_BITS = $clog2(NUM_CHANNELS);
  localparam int CAW     = ADDR_WIDTH - CH_BITS;
  localparam int BEW     = DATA_WIDTH / 8;
  localparam int NC      = NUM_CHANNELS;

  logic                     in_req_valid;
  logic                     in_req_rw;
  logic [BEW-1:0]           in_req_byteen;
  logic [ADDR_WIDTH-1:0]    in_req_addr;
  logic [DATA_WIDTH-1:0]    in_req_data;
  logic [TAG_WIDTH-1:0]     in_req_tag;
  logic                     in_req_ready;

  logic                     in_rsp_valid;
  logic [DATA_WIDTH-1:0]    in_rsp_data;
  logic [TAG_WIDTH-1:0]     in_rsp_tag;
  logic                     in_rsp_ready;

  logic [NC-1:0]            mem_req_valid;
  logic [NC-1:0]            mem_req_rw;
  logic [NC*BEW-1:0]        mem_req_byteen;
  logic [NC*CAW-1:0]        mem_req_addr;
  logic [NC*DATA_WIDTH-1:0] mem_req_data;
  logic [NC*TAG_WIDTH-1:0]  mem_req_tag;
  logic [NC-1:0]            mem_req_ready;

  logic [NC-1:0]            mem_rsp_valid;
  logic [NC*DATA_WIDTH-1:0] mem_rsp_data;
  logic [NC*TAG_WIDTH-1:0]  mem_rsp_tag;
  logic [NC-1:0]            mem_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_byteen,
    input  in_req_addr, in_req_data, in_req_tag,
    output in_req_ready,
    output in_rsp_valid, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready,
    output mem_req_valid, mem_req_rw, mem_req_byteen,
    output mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_byteen,
    output in_req_addr, in_req_data, in_req_tag,
    input  in_req_ready,
    input  in_rsp_valid, in_rsp_data, in_rsp_tag,
    output in_rsp_ready,
    input  mem_req_valid, mem_req_rw, mem_req_byteen,
    input  mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_mem_chan_interleave.sv
// vx_mem_chan_interleave: address-interleaved split of one request
// stream over N channels, round-robin merge of their responses.
module vx_mem_chan_interleave #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 512,
  parameter int TAG_WIDTH      = 8,
  parameter int INTERLEAVE_LSB = 0,
  parameter int PENDING_WIDTH  = 8,
  parameter int PERF_CTR_BITS  = 44
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_mem_chan_interleave_if.slave  bus,
  output logic [PERF_CTR_BITS-1:0] perf_reads,
  output logic [PERF_CTR_BITS-1:0] perf_writes,
  output logic [PERF_CTR_BITS-1:0] perf_latency,
  output logic                     busy
);
  localparam int NC      = NUM_CHANNELS;
  localparam int CH_BITS = $clog2(NC);
  localparam int CAW     = ADDR_WIDTH - CH_BITS;
  localparam int BEW     = DATA_WIDTH / 8;
  localparam int PTR_W   = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int REQ_W   = 1 + BEW + CAW + DATA_WIDTH + TAG_WIDTH;
  localparam int RSP_W   = DATA_WIDTH + TAG_WIDTH;
  localparam int SUM_W   = PENDING_WIDTH + 4;
  localparam logic [PENDING_WIDTH:0] PEND_MAX =
    (PENDING_WIDTH+1)'((1 << PENDING_WIDTH) - 1);
  localparam logic [ADDR_WIDTH-1:0] LO_MASK =
    ADDR_WIDTH'((64'd1 << INTERLEAVE_LSB) - 64'd1);

  logic [PTR_W-1:0]   sel;
  logic [CAW-1:0]     ch_addr;
  logic [REQ_W-1:0]   req_pkt;
  logic               in_fire;
  logic               gate_ok;
  logic [PENDING_WIDTH:0] rd_load;

  logic [REQ_W-1:0]   rq_mem [NC][2];
  logic [NC-1:0]      rq_rd, rq_wr, rq_push, rq_pop, rq_nz;
  logic [NC-1:0]      rd_fire, rsp_fire, pend_nz;
  logic [NC-1:0][1:0] rq_cnt, rq_nrd;
  logic [NC-1:0][PENDING_WIDTH-1:0] pending;
  logic [SUM_W-1:0]   pend_sum;

  logic [PTR_W-1:0]   rr_ptr, gnt;
  logic               gnt_any;
  logic [RSP_W-1:0]   rs_mem [2];
  logic               rs_rd, rs_wr, rs_push, rs_pop;
  logic [1:0]         rs_cnt;
  logic [RSP_W-1:0]   rsp_pkt;

  if (CH_BITS == 0) begin : g_sel1
    assign sel = '0;
  end else begin : g_seln
    assign sel = bus.in_req_addr[INTERLEAVE_LSB +: CH_BITS];
  end

  assign ch_addr = CAW'(
    ((bus.in_req_addr >> (INTERLEAVE_LSB + CH_BITS))
      << INTERLEAVE_LSB) | (bus.in_req_addr & LO_MASK));

  assign req_pkt = {bus.in_req_rw, bus.in_req_byteen, ch_addr,
                    bus.in_req_data, bus.in_req_tag};

  // Reads in flight plus reads still buffered must stay below max
  assign rd_load = {1'b0, pending[sel]}
                 + (PENDING_WIDTH+1)'(rq_nrd[sel]);
  assign gate_ok = bus.in_req_rw | (rd_load < PEND_MAX);
  assign bus.in_req_ready = (rq_cnt[sel] != 2'd2) & gate_ok;
  assign in_fire = bus.in_req_valid & bus.in_req_ready;

  for (genvar c = 0; c < NC; c++) begin : g_ch
    logic [REQ_W-1:0] head;
    assign head = rq_mem[c][rq_rd[c]];
    assign rq_nz[c] = rq_cnt[c] != 2'd0;
    assign bus.mem_req_valid[c] = rq_nz[c];
    assign {bus.mem_req_rw[c],
            bus.mem_req_byteen[c*BEW +: BEW],
            bus.mem_req_addr[c*CAW +: CAW],
            bus.mem_req_data[c*DATA_WIDTH +: DATA_WIDTH],
            bus.mem_req_tag[c*TAG_WIDTH +: TAG_WIDTH]} = head;
    assign rq_push[c]  = in_fire & (sel == PTR_W'(c));
    assign rq_pop[c]   = rq_nz[c] & bus.mem_req_ready[c];
    assign rd_fire[c]  = rq_pop[c] & ~head[REQ_W-1];
    assign rsp_fire[c] = bus.mem_rsp_valid[c]
                       & bus.mem_rsp_ready[c];
    assign pend_nz[c]  = pending[c] != '0;
    assign rq_nrd[c] =
      2'(rq_nz[c] & ~head[REQ_W-1]) +
      2'((rq_cnt[c] == 2'd2) &
         ~rq_mem[c][~rq_rd[c]][REQ_W-1]);
  end

  // Per-channel 2-entry request FIFOs
  always_ff @(posedge clk) begin
    if (reset) begin
      rq_cnt <= '0;
      rq_rd  <= '0;
      rq_wr  <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (rq_push[c]) begin
          rq_mem[c][rq_wr[c]] <= req_pkt;
          rq_wr[c] <= ~rq_wr[c];
        end
        if (rq_pop[c]) rq_rd[c] <= ~rq_rd[c];
        rq_cnt[c] <= rq_cnt[c] + 2'(rq_push[c])
                   - 2'(rq_pop[c]);
      end
    end
  end

  // Outstanding reads per channel; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (rd_fire[c] && !rsp_fire[c])
          pending[c] <= pending[c] + 1'b1;
        else if (!rd_fire[c] && rsp_fire[c] && pend_nz[c])
          pending[c] <= pending[c] - 1'b1;
      end
    end
  end

`ifdef SIMULATION
  // Flag a response arriving with no read outstanding
  always_ff @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (!reset && rsp_fire[c] && !rd_fire[c])
        assert (pending[c] != '0)
        else $error("pending underflow ch %0d", c);
    end
  end
`endif

  // Round-robin search starting at rr_ptr
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (!gnt_any &&
          bus.mem_rsp_valid[(int'(rr_ptr) + i) % NC]) begin
        gnt_any = 1'b1;
        gnt = PTR_W'((int'(rr_ptr) + i) % NC);
      end
    end
  end

  // Only the granted channel sees ready, and only with room
  always_comb begin
    bus.mem_rsp_ready = '0;
    if (gnt_any && rs_cnt != 2'd2)
      bus.mem_rsp_ready[gnt] = 1'b1;
  end

  assign rsp_pkt = {
    bus.mem_rsp_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH],
    bus.mem_rsp_tag[int'(gnt)*TAG_WIDTH +: TAG_WIDTH]};
  assign rs_push = |rsp_fire;
  assign rs_pop  = bus.in_rsp_valid & bus.in_rsp_ready;
  assign bus.in_rsp_valid = rs_cnt != 2'd0;
  assign {bus.in_rsp_data, bus.in_rsp_tag} = rs_mem[rs_rd];

  // Response FIFO and arbiter pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      rs_rd  <= 1'b0;
      rs_wr  <= 1'b0;
      rs_cnt <= '0;
    end else begin
      if (rs_push) begin
        rs_mem[rs_wr] <= rsp_pkt;
        rs_wr  <= ~rs_wr;
        rr_ptr <= PTR_W'((int'(gnt) + 1) % NC);
      end
      if (rs_pop) rs_rd <= ~rs_rd;
      rs_cnt <= rs_cnt + 2'(rs_push) - 2'(rs_pop);
    end
  end

  // Total reads in flight across channels
  always_comb begin
    pend_sum = '0;
    for (int c = 0; c < NC; c++)
      pend_sum = pend_sum + SUM_W'(pending[c]);
  end

  // Perf counters, wrapping at their width
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads   <= '0;
      perf_writes  <= '0;
      perf_latency <= '0;
    end else begin
      if (in_fire && !bus.in_req_rw)
        perf_reads <= perf_reads + 1'b1;
      if (in_fire && bus.in_req_rw)
        perf_writes <= perf_writes + 1'b1;
      perf_latency <= perf_latency
                    + PERF_CTR_BITS'(pend_sum);
    end
  end

  assign busy = (|pend_nz) | (|rq_nz) | (rs_cnt != 2'd0);
endmodule
